// File: rtl/prbs_pkg.sv
// prbs_pkg: XNOR Fibonacci LFSR tap table, multi-step helper and checker state type
package prbs_pkg;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_e;

    typedef struct packed {
        logic [31:0] state;
        logic [31:0] word;
    } prbs_step_t;

    // tap masks: bit (t-1) set for each 1-based XAPP052 tap t
    function automatic logic [31:0] prbs_taps(input int n);
        case (n)
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0004_0023;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            32: return 32'h8020_0003;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic prbs_fb(input int n, input logic [31:0] s);
        return ~^(s & prbs_taps(n));
    endfunction

    // w single steps; the first feedback bit lands in word bit w-1
    function automatic prbs_step_t prbs_step_w(input int n, input int w, input logic [31:0] s);
        prbs_step_t r;
        logic [31:0] m;
        logic fb;
        m = (n >= 32) ? '1 : (32'h1 << n) - 32'h1;
        r.state = s & m;
        r.word = '0;
        for (int k = 0; k < w; k++) begin
            fb = prbs_fb(n, r.state);
            r.state = ((r.state << 1) | {31'b0, fb}) & m;
            r.word = {r.word[30:0], fb};
        end
        return r;
    endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// prbs_gen_chk_if: pattern generator and checker signal bundle
interface prbs_gen_chk_if #(
    parameter int N = 8,
    parameter int W = 1,
    parameter int ERR_W = 16
);
    logic             clk_en_i;
    logic             seed_load_i;
    logic [N-1:0]     seed_i;
    logic [W-1:0]     gen_data_o;
    logic             chk_en_i;
    logic [W-1:0]     chk_data_i;
    logic             err_clr_i;
    logic             chk_lock_o;
    logic [ERR_W-1:0] err_cnt_o;

    modport master (
        output clk_en_i, seed_load_i, seed_i, chk_en_i, chk_data_i, err_clr_i,
        input  gen_data_o, chk_lock_o, err_cnt_o
    );

    modport slave (
        input  clk_en_i, seed_load_i, seed_i, chk_en_i, chk_data_i, err_clr_i,
        output gen_data_o, chk_lock_o, err_cnt_o
    );
endinterface

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker with lock detection and saturating bit-error count
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [W-1:0]     data_i,
    input  logic             clr_i,
    output logic             lock_o,
    output logic [ERR_W-1:0] err_cnt_o
);
    localparam int HW = $clog2(N + W + 1);
    localparam int VW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int SW = ERR_W + $clog2(W + 1);

    chk_state_e   state_q;
    logic [N-1:0] chk_state;
    logic [HW-1:0] hunt_cnt;
    logic [HW-1:0] hunt_next;
    logic [VW-1:0] ok_cnt;
    logic [LW-1:0] loss_cnt;
    logic [N+W-1:0] shifted;
    logic [W-1:0] diff;
    logic [SW-1:0] err_sum;
    prbs_step_t   step;
    logic         unused_step;

    assign step        = prbs_step_w(N, W, 32'(chk_state));
    assign unused_step = ^step;
    assign shifted     = {chk_state, data_i};
    assign diff        = step.word[W-1:0] ^ data_i;
    assign hunt_next   = hunt_cnt + HW'(W);
    assign err_sum     = SW'(err_cnt_o) + SW'($countones(diff));

    // once synchronised, the local LFSR free-runs on its own predictions
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= HUNT;
            chk_state <= '0;
            hunt_cnt  <= '0;
            ok_cnt    <= '0;
            loss_cnt  <= '0;
            lock_o    <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            if (clr_i)
                err_cnt_o <= '0;
            else if (en_i && state_q == LOCKED)
                err_cnt_o <= |err_sum[SW-1:ERR_W] ? '1 : err_sum[ERR_W-1:0];
            if (en_i) begin
                case (state_q)
                    HUNT: begin
                        chk_state <= shifted[N-1:0];
                        hunt_cnt  <= hunt_next >= HW'(N) ? '0 : hunt_next;
                        if (hunt_next >= HW'(N) && !(&shifted[N-1:0])) begin
                            state_q <= VERIFY;
                            ok_cnt  <= '0;
                        end
                    end
                    VERIFY: begin
                        chk_state <= step.state[N-1:0];
                        if (|diff) begin
                            state_q <= HUNT;
                            ok_cnt  <= '0;
                        end else if (ok_cnt == VW'(LOCK_CNT - 1)) begin
                            state_q  <= LOCKED;
                            lock_o   <= 1'b1;
                            loss_cnt <= '0;
                        end else
                            ok_cnt <= ok_cnt + VW'(1);
                    end
                    LOCKED: begin
                        chk_state <= step.state[N-1:0];
                        if (!(|diff))
                            loss_cnt <= '0;
                        else if (loss_cnt == LW'(LOSS_CNT - 1)) begin
                            state_q  <= HUNT;
                            lock_o   <= 1'b0;
                            loss_cnt <= '0;
                        end else
                            loss_cnt <= loss_cnt + LW'(1);
                    end
                    default: begin
                        state_q <= HUNT;
                        lock_o  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: W-bit-per-cycle PRBS pattern generator with an independent self-synchronising checker
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    prbs_gen_chk_if.slave  bus
);
    if (N < 3 || N > 32) begin : g_bad_n
        $error("prbs_gen_chk: N must be in 3..32");
    end
    if (W < 1 || W > N) begin : g_bad_w
        $error("prbs_gen_chk: W must be in 1..N");
    end

    logic [N-1:0] g_state;
    logic [W-1:0] g_word;
    prbs_step_t   g_step;
    logic         unused_step;

    assign g_step         = prbs_step_w(N, W, 32'(g_state));
    assign unused_step    = ^g_step;
    assign bus.gen_data_o = g_word;

    // all-ones is the XNOR lock-up state, so such a seed is replaced by zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            g_state <= '0;
            g_word  <= '0;
        end else if (bus.seed_load_i)
            g_state <= &bus.seed_i ? '0 : bus.seed_i;
        else if (bus.clk_en_i) begin
            g_state <= g_step.state[N-1:0];
            g_word  <= g_step.word[W-1:0];
        end
    end

    prbs_chk #(
        .N(N), .W(W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)
    ) u_chk (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (bus.chk_en_i),
        .data_i    (bus.chk_data_i),
        .clr_i     (bus.err_clr_i),
        .lock_o    (bus.chk_lock_o),
        .err_cnt_o (bus.err_cnt_o)
    );
endmodule
